// File: rtl/sin_voice_sched.sv
// Time-multiplexed sine voice scheduler: walks NVOICE phase accumulators through
// one shared quarter-wave ROM and mixes the signed amplitudes into one sample per tick.
module sin_voice_sched #(
  parameter int unsigned NVOICE  = 4,
  parameter int unsigned PHASE_W = 12,
  localparam int unsigned SEL_W  = $clog2(NVOICE),
  localparam int unsigned OUT_W  = 6 + SEL_W
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    sample_tick,
  input  logic [NVOICE-1:0]       voice_en,
  input  logic                    freq_we,
  input  logic [SEL_W-1:0]        freq_sel,
  input  logic [PHASE_W-1:0]      freq_val,
  output logic                    rom_en,
  output logic [4:0]              rom_addr,
  input  logic [5:0]              rom_data,
  output logic signed [OUT_W-1:0] sample_out,
  output logic                    sample_valid,
  output logic                    busy,
  output logic                    overrun
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [SEL_W-1:0]        r_k;
  logic [SEL_W-1:0]        w_slot_next;
  logic                    w_start;
  logic                    w_issue;
  logic [PHASE_W-1:0]      r_phase [NVOICE];
  logic [PHASE_W-1:0]      r_freq  [NVOICE];
  logic                    r_pend;
  logic                    r_sign;
  logic signed [OUT_W-1:0] r_acc;
  logic signed [OUT_W-1:0] r_sample_out;
  logic signed [OUT_W-1:0] w_amp;
  logic [4:0]              r_rom_addr;
  logic                    r_sample_valid;
  logic                    r_busy;
  logic                    r_overrun;

  // Fold the top phase bits (q[0], idx) onto the quarter-wave table
  function automatic logic [4:0] fold(input logic [5:0] top);
    return top[5] ? (5'd31 - top[4:0]) : top[4:0];
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    if (!en) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (sample_tick && !r_busy) begin
            w_state_next = S_ISSUE;
            w_start      = 1'b1;
          end
        end
        S_ISSUE: if (r_k == SEL_W'(NVOICE - 1)) w_state_next = S_DRAIN;
        S_DRAIN: w_state_next = S_OUT;
        S_OUT:   w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_issue     = en && (r_state == S_ISSUE);
    w_slot_next = (r_state == S_ISSUE) ? (r_k + SEL_W'(1)) : '0;
    w_amp       = signed'(OUT_W'(rom_data));
  end

  // ROM enable follows voice_en live so each slot samples it in its own issue cycle
  assign rom_en       = w_issue && voice_en[r_k];
  assign rom_addr     = r_rom_addr;
  assign sample_out   = r_sample_out;
  assign sample_valid = r_sample_valid;
  assign busy         = r_busy;
  assign overrun      = r_overrun;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(NVOICE); i++) r_freq[i] <= '0;
    end else if (freq_we) begin
      r_freq[freq_sel] <= freq_val;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(NVOICE); i++) r_phase[i] <= '0;
      r_k            <= '0;
      r_rom_addr     <= '0;
      r_pend         <= 1'b0;
      r_sign         <= 1'b0;
      r_acc          <= '0;
      r_sample_out   <= '0;
      r_sample_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_k <= (w_state_next == S_ISSUE) ? w_slot_next : '0;
      // Address is looked ahead one edge so it is registered during the issue cycle
      if (w_state_next == S_ISSUE)
        r_rom_addr <= fold(r_phase[w_slot_next][PHASE_W-2 -: 6]);
      if (rom_en)
        r_phase[r_k] <= r_phase[r_k] + r_freq[r_k];
      r_pend <= w_issue;
      r_sign <= r_phase[r_k][PHASE_W-1];
      if (w_start)     r_acc <= '0;
      else if (r_pend) r_acc <= r_sign ? (r_acc - w_amp) : (r_acc + w_amp);
      if (en && (r_state == S_OUT)) r_sample_out <= r_acc;
      r_sample_valid <= en && (r_state == S_OUT);
      r_busy         <= (w_state_next != S_IDLE) || (en && (r_state == S_OUT));
      r_overrun      <= en && sample_tick && r_busy;
    end
  end

endmodule

// File: tb/tb_sin_voice_sched.sv
// Scoreboard bench for sin_voice_sched: a phase-arithmetic voice model predicts each
// mixed sample; a monitor pops predictions on sample_valid.
module tb_sin_voice_sched;
  localparam int NVOICE  = 4;
  localparam int PHASE_W = 12;
  localparam int OUT_W   = 8;
  localparam int PMOD    = 1 << PHASE_W;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic                    en;
  logic                    sample_tick;
  logic [NVOICE-1:0]       voice_en;
  logic                    freq_we;
  logic [1:0]              freq_sel;
  logic [PHASE_W-1:0]      freq_val;
  logic                    rom_en;
  logic [4:0]              rom_addr;
  logic [5:0]              rom_data;
  logic signed [OUT_W-1:0] sample_out;
  logic                    sample_valid;
  logic                    busy;
  logic                    overrun;

  int rom_tbl [32];
  int m_phase [NVOICE];
  int m_freq  [NVOICE];
  int m_pre0;
  int exp_q [$];
  int n_chk  = 0;
  int n_pass = 0;

  sin_voice_sched dut (
    .clk(clk), .rstn(rstn), .en(en), .sample_tick(sample_tick), .voice_en(voice_en),
    .freq_we(freq_we), .freq_sel(freq_sel), .freq_val(freq_val), .rom_en(rom_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .sample_out(sample_out),
    .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Quarter-wave ROM: registered read, zero when not enabled
  always @(posedge clk) rom_data <= rom_en ? 6'(rom_tbl[rom_addr]) : 6'd0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int addr_of(input int ph);
    int q   = ph >> (PHASE_W - 2);
    int idx = (ph >> (PHASE_W - 7)) % 32;
    return (q % 2 == 1) ? 31 - idx : idx;
  endfunction

  function automatic int amp_of(input int ph);
    int q = ph >> (PHASE_W - 2);
    return (q >= 2) ? -rom_tbl[addr_of(ph)] : rom_tbl[addr_of(ph)];
  endfunction

  task automatic frame_model(output int s);
    s      = 0;
    m_pre0 = m_phase[0];
    for (int k = 0; k < NVOICE; k++) begin
      if (voice_en[k]) begin
        s += amp_of(m_phase[k]);
        m_phase[k] = (m_phase[k] + m_freq[k]) % PMOD;
      end
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NVOICE; k++) begin
      m_phase[k] = 0;
      m_freq[k]  = 0;
    end
  endtask

  task automatic wr_freq(input int v, input int f);
    freq_we  = 1'b1;
    freq_sel = 2'(v);
    freq_val = 12'(f);
    @(negedge clk);
    freq_we  = 1'b0;
    m_freq[v] = f;
  endtask

  // Fire one tick and walk the frame, checking slot timing against the model
  task automatic run_frame(input bit has_const, input int const_v);
    int s;
    frame_model(s);
    exp_q.push_back(s);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 1) chk("rom_addr_slot0", int'(rom_addr), addr_of(m_pre0));
      chk("rom_en", int'(rom_en), (c <= NVOICE) ? int'(voice_en[c-1]) : 0);
      chk("busy", int'(busy), (c <= NVOICE + 3) ? 1 : 0);
      chk("sample_valid", int'(sample_valid), (c == NVOICE + 3) ? 1 : 0);
      chk("overrun_idle", int'(overrun), 0);
      if (has_const && c == NVOICE + 3) chk("sample_const", int'(sample_out), const_v);
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    if (rstn === 1'b1 && sample_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
      else chk("scoreboard_sample", int'(sample_out), exp_q.pop_front());
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    int so, vcount, s;
    for (int a = 0; a < 32; a++)
      rom_tbl[a] = $rtoi($floor(31.0 * $sin(3.14159265358979 * real'(a) / 62.0) + 0.5));
    model_clear();
    rstn = 1'b0; en = 1'b0; sample_tick = 1'b0; voice_en = '0;
    freq_we = 1'b0; freq_sel = '0; freq_val = '0;
    repeat (2) @(negedge clk);
    chk("rst_sample_out", int'(sample_out), 0);
    chk("rst_rom_en", int'(rom_en), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    rstn = 1'b1; en = 1'b1;
    @(negedge clk);

    // Single voice sweeping the full cycle
    voice_en = 4'b0001;
    wr_freq(0, 32);
    for (int n = 0; n <= 96; n++) begin
      case (n)
        0, 64:   run_frame(1'b1, 0);
        8:       run_frame(1'b1, 12);
        32:      run_frame(1'b1, 31);
        96:      run_frame(1'b1, -31);
        default: run_frame(1'b0, 0);
      endcase
      repeat (3) @(negedge clk);
    end

    // Four voices in phase, quarter-cycle steps
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    model_clear();
    voice_en = 4'b1111;
    for (int v = 0; v < NVOICE; v++) wr_freq(v, 1024);
    run_frame(1'b1, 0);
    run_frame(1'b1, 124);
    run_frame(1'b1, 0);
    run_frame(1'b1, -124);
    run_frame(1'b1, 0);
    voice_en = 4'b0101;
    run_frame(1'b1, 62);
    voice_en = 4'b1111;
    run_frame(1'b1, 62);

    // Overlapping tick plus freq write during voice 2's slot
    frame_model(s);
    exp_q.push_back(s);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sample_tick = 1'b1; freq_we = 1'b1; freq_sel = 2'd2; freq_val = 12'd512;
    @(negedge clk);
    sample_tick = 1'b0; freq_we = 1'b0;
    m_freq[2] = 512;
    chk("overrun_pulse", int'(overrun), 1);
    vcount = 0;
    for (int c = 4; c <= 12; c++) begin
      if (c == 5) chk("overrun_single", int'(overrun), 0);
      if (sample_valid) vcount++;
      @(negedge clk);
    end
    chk("overrun_one_valid", vcount, 1);
    run_frame(1'b0, 0);
    run_frame(1'b0, 0);

    // Randomised voice enables and frequencies
    repeat (24) begin
      voice_en = 4'($urandom);
      repeat (2) wr_freq(int'($urandom_range(0, 3)), int'($urandom_range(0, PMOD - 1)));
      run_frame(1'b0, 0);
    end

    // Enable dropped in slot 2: voices 0 and 1 already advanced
    voice_en = 4'b1111;
    so = int'(sample_out);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    #1;
    chk("abort_rom_en", int'(rom_en), 0);
    for (int k = 0; k < 2; k++) m_phase[k] = (m_phase[k] + m_freq[k]) % PMOD;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    chk("abort_no_overrun", int'(overrun), 0);
    vcount = 0;
    repeat (8) begin
      if (sample_valid) vcount++;
      @(negedge clk);
    end
    chk("abort_no_valid", vcount, 0);
    chk("abort_hold_sample", int'(sample_out), so);
    en = 1'b1;
    @(negedge clk);
    run_frame(1'b0, 0);

    // Reset in the middle of a frame
    for (int v = 0; v < NVOICE; v++) wr_freq(v, int'($urandom_range(1, PMOD - 1)));
    run_frame(1'b0, 0);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midrst_rom_en", int'(rom_en), 0);
    chk("midrst_rom_addr", int'(rom_addr), 0);
    chk("midrst_sample_out", int'(sample_out), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_valid", int'(sample_valid), 0);
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_frame(1'b1, 0);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
